// File: rtl/fifo_shift_datapath.sv
// Storage and read path of the shift-register FIFO: words shift in at mem[0], the oldest is read at mem[pc-1].
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module fifo_shift_datapath #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DEPTH-1:0]  pc,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              full,
    output logic              empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic              ovf,
    output logic              unf
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DEPTH_U = DEPTH;
    localparam logic [DEPTH-1:0] PC_FULL = DEPTH'(DEPTH - 1);

    // Read index pc-1, saturated to the last entry so an illegal pc never reads out of range.
    function automatic logic [IDX_W-1:0] sat_idx(input logic [DEPTH-1:0] p);
        int unsigned pv;
        pv = 32'(p);
        if (pv == 0)
            return '0;
        else if (pv >= DEPTH_U)
            return IDX_W'(DEPTH_U - 1);
        else
            return IDX_W'(pv - 1);
    endfunction

    logic [DATA_W-1:0] mem_p0 [DEPTH];
    logic [DATA_W-1:0] rd_word_p0;
    logic              shift_p0;
    logic              rd_p0;
    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;

    assign full  = (pc == PC_FULL);
    assign empty = (pc == '0);

    // A simultaneous pop makes room, so push&pop shifts even when full (and at pc==0).
    assign shift_p0   = push & (pop | ~full);
    assign rd_p0      = pop & ~empty;
    assign rd_word_p0 = mem_p0[sat_idx(pc)];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_p0[i] <= '0;
            if (push & pop)
                mem_p0[0] <= data_in;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            if (shift_p0) begin
                for (int i = 1; i < DEPTH; i++)
                    mem_p0[i] <= mem_p0[i-1];
                mem_p0[0] <= data_in;
            end
            if (rd_p0)
                data_p1 <= rd_word_p0;
            vld_p1 <= rd_p0;
        end
    end

    // ---- stage p1: registered read port ----
    assign data_out = data_p1;
    assign valid    = vld_p1;

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (push & full & ~pop)
                ovf <= 1'b1;
            if (pop & empty & ~push)
                unf <= 1'b1;
        end
    end
`endif

endmodule
